// File: rtl/spi_burst_fsm_if.sv
// ============================================================================
//  Module      : spi_burst_fsm_if
//  Description : Control/handshake bundle between the SPI input conditioners,
//                the burst sequencer and the datapath enables.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface spi_burst_fsm_if #(
    parameter int WC_BITS = 8
);
    logic               cs_n;
    logic               sclk_pos;
    logic               rw_bit;
    logic               addr_we;
    logic               sr_we;
    logic               dm_we;
    logic               miso_buff;
    logic               addr_inc;
    logic               overrun;
    logic [WC_BITS-1:0] word_count;

    modport master (
        output cs_n, sclk_pos, rw_bit,
        input  addr_we, sr_we, dm_we, miso_buff, addr_inc, overrun, word_count
    );

    modport slave (
        input  cs_n, sclk_pos, rw_bit,
        output addr_we, sr_we, dm_we, miso_buff, addr_inc, overrun, word_count
    );
endinterface

`default_nettype wire

// File: rtl/spi_burst_fsm.sv
// ============================================================================
//  Module      : spi_burst_fsm
//  Description : SPI memory-slave frame sequencer: header/data bit counting,
//                burst auto-increment, word count and overrun detection.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_burst_fsm #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 8,
    parameter bit BURST_EN  = 1'b1,
    parameter int WC_BITS   = 8
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    spi_burst_fsm_if.slave   bus
);

    localparam int C_MAXB = ((ADDR_BITS + 1) > DATA_BITS) ? (ADDR_BITS + 1) : DATA_BITS;
    localparam int C_CW   = $clog2(C_MAXB + 1);
    localparam logic [C_CW-1:0] C_ADDR_LAST = C_CW'(ADDR_BITS);
    localparam logic [C_CW-1:0] C_DATA_LAST = C_CW'(DATA_BITS - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_LATCH     = 4'd2,
        S_RD_LOAD   = 4'd3,
        S_RD_SHIFT  = 4'd4,
        S_WR_SHIFT  = 4'd5,
        S_WR_COMMIT = 4'd6,
        S_INC       = 4'd7,
        S_DONE      = 4'd8
    } state_t;

    state_t             state_q, state_d;
    logic [C_CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic               rd_flag_q, rd_flag_d;
    logic [WC_BITS-1:0] wc_q, wc_d, wc_sat_inc;
    logic               ovr_q, ovr_d;
    logic               cnt_inc;
    logic               addr_we_q, addr_we_d;
    logic               sr_we_q, sr_we_d;
    logic               dm_we_q, dm_we_d;
    logic               miso_q, miso_d;
    logic               addr_inc_q, addr_inc_d;

    always_comb begin
        state_d    = state_q;
        rd_flag_d  = rd_flag_q;
        wc_d       = wc_q;
        ovr_d      = ovr_q;
        cnt_inc    = 1'b0;
        wc_sat_inc = (&wc_q) ? wc_q : wc_q + 1'b1;

        // Chip-select release wins over any SCLK edge in the same cycle.
        if (bus.cs_n) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_ADDR;
                    wc_d    = '0;
                    ovr_d   = 1'b0;
                end
                S_ADDR: begin
                    if (bus.sclk_pos) begin
                        if (bit_cnt_q == C_ADDR_LAST) state_d = S_LATCH;
                        else                          cnt_inc = 1'b1;
                    end
                end
                S_LATCH: begin
                    rd_flag_d = bus.rw_bit;
                    state_d   = bus.rw_bit ? S_RD_LOAD : S_WR_SHIFT;
                    if (bus.sclk_pos) ovr_d = 1'b1;
                end
                S_RD_LOAD: begin
                    state_d = S_RD_SHIFT;
                    if (bus.sclk_pos) ovr_d = 1'b1;
                end
                S_RD_SHIFT: begin
                    if (bus.sclk_pos) begin
                        if (bit_cnt_q == C_DATA_LAST) begin
                            wc_d    = wc_sat_inc;
                            state_d = BURST_EN ? S_INC : S_DONE;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
                S_WR_SHIFT: begin
                    if (bus.sclk_pos) begin
                        if (bit_cnt_q == C_DATA_LAST) state_d = S_WR_COMMIT;
                        else                          cnt_inc = 1'b1;
                    end
                end
                S_WR_COMMIT: begin
                    wc_d    = wc_sat_inc;
                    state_d = BURST_EN ? S_INC : S_DONE;
                    if (bus.sclk_pos) ovr_d = 1'b1;
                end
                S_INC: begin
                    state_d = rd_flag_q ? S_RD_LOAD : S_WR_SHIFT;
                    if (bus.sclk_pos) ovr_d = 1'b1;
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end

        if (state_d != state_q) bit_cnt_d = '0;
        else if (cnt_inc)       bit_cnt_d = bit_cnt_q + 1'b1;
        else                    bit_cnt_d = bit_cnt_q;

        // Enables are decoded from the next state so they line up with it.
        addr_we_d  = (state_d == S_ADDR);
        sr_we_d    = (state_d == S_RD_LOAD);
        dm_we_d    = (state_d == S_WR_COMMIT);
        addr_inc_d = (state_d == S_INC);
        miso_d     = (state_d == S_RD_LOAD) || (state_d == S_RD_SHIFT) ||
                     ((state_d == S_INC) && rd_flag_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            rd_flag_q  <= 1'b0;
            wc_q       <= '0;
            ovr_q      <= 1'b0;
            addr_we_q  <= 1'b0;
            sr_we_q    <= 1'b0;
            dm_we_q    <= 1'b0;
            miso_q     <= 1'b0;
            addr_inc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rd_flag_q  <= rd_flag_d;
            wc_q       <= wc_d;
            ovr_q      <= ovr_d;
            addr_we_q  <= addr_we_d;
            sr_we_q    <= sr_we_d;
            dm_we_q    <= dm_we_d;
            miso_q     <= miso_d;
            addr_inc_q <= addr_inc_d;
        end
    end

    assign bus.addr_we    = addr_we_q;
    assign bus.sr_we      = sr_we_q;
    assign bus.dm_we      = dm_we_q;
    assign bus.miso_buff  = miso_q;
    assign bus.addr_inc   = addr_inc_q;
    assign bus.overrun    = ovr_q;
    assign bus.word_count = wc_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_burst_fsm.sv
// ============================================================================
//  Module      : tb_spi_burst_fsm
//  Description : Self-checking bench for spi_burst_fsm in three configurations
//                (default burst, single-word, 15/16-bit burst).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_burst_fsm;

    logic clk;
    logic reset_n;
    int   cyc = 0;

    logic [2:0] cs_n, sclk, rw, win;
    logic [2:0] o_dm, o_sr, o_inc, o_miso, o_awe, o_ovr;
    logic [7:0] o_wc [3];

    int n_cmp  = 0;
    int n_fail = 0;
    int miso_bad = 0;
    int mon_idx;

    typedef struct { int d; bit rd; int nd; int tail; bit inject; int exp_wc; } vec_t;
    typedef struct { int d; int k; int cyc; } ev_t;
    ev_t  sb[$];
    vec_t vt[8];

    spi_burst_fsm_if #(.WC_BITS(8)) b0 ();
    spi_burst_fsm_if #(.WC_BITS(8)) b1 ();
    spi_burst_fsm_if #(.WC_BITS(8)) b2 ();

    spi_burst_fsm #(.ADDR_BITS(7),  .DATA_BITS(8),  .BURST_EN(1'b1), .WC_BITS(8))
        u0 (.clk(clk), .reset_n(reset_n), .bus(b0));
    spi_burst_fsm #(.ADDR_BITS(7),  .DATA_BITS(8),  .BURST_EN(1'b0), .WC_BITS(8))
        u1 (.clk(clk), .reset_n(reset_n), .bus(b1));
    spi_burst_fsm #(.ADDR_BITS(15), .DATA_BITS(16), .BURST_EN(1'b1), .WC_BITS(8))
        u2 (.clk(clk), .reset_n(reset_n), .bus(b2));

    assign b0.cs_n = cs_n[0];  assign b0.sclk_pos = sclk[0];  assign b0.rw_bit = rw[0];
    assign b1.cs_n = cs_n[1];  assign b1.sclk_pos = sclk[1];  assign b1.rw_bit = rw[1];
    assign b2.cs_n = cs_n[2];  assign b2.sclk_pos = sclk[2];  assign b2.rw_bit = rw[2];

    assign o_dm   = {b2.dm_we,     b1.dm_we,     b0.dm_we};
    assign o_sr   = {b2.sr_we,     b1.sr_we,     b0.sr_we};
    assign o_inc  = {b2.addr_inc,  b1.addr_inc,  b0.addr_inc};
    assign o_miso = {b2.miso_buff, b1.miso_buff, b0.miso_buff};
    assign o_awe  = {b2.addr_we,   b1.addr_we,   b0.addr_we};
    assign o_ovr  = {b2.overrun,   b1.overrun,   b0.overrun};
    assign o_wc[0] = b0.word_count;
    assign o_wc[1] = b1.word_count;
    assign o_wc[2] = b2.word_count;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit out_bit(input int d, input int k);
        case (k)
            0:       return o_dm[d];
            1:       return o_sr[d];
            default: return o_inc[d];
        endcase
    endfunction

    // Every observed pulse must match a predicted (dut, kind, cycle) entry.
    task automatic sample();
        for (int d = 0; d < 3; d++) begin
            if (win[d] && !o_miso[d]) miso_bad++;
            for (int k = 0; k < 3; k++) begin
                if (out_bit(d, k)) begin
                    mon_idx = -1;
                    foreach (sb[i])
                        if (mon_idx < 0 && sb[i].d == d && sb[i].k == k && sb[i].cyc == cyc)
                            mon_idx = i;
                    n_cmp++;
                    if (mon_idx < 0) begin
                        n_fail++;
                        $display("FAIL pulse dut%0d kind%0d: got pulse at cycle %0d, expected none", d, k, cyc);
                    end else begin
                        sb.delete(mon_idx);
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int d, output int m);
        sclk[d] = 1'b1;
        m = cyc;
        tick();
        sclk[d] = 1'b0;
    endtask

    task automatic push(input int d, input int k, input int c);
        sb.push_back('{d, k, c});
    endtask

    task automatic run_frame(input vec_t v);
        int nh, db, m, lim, bad0;
        bit bu;
        nh   = (v.d == 2) ? 16 : 8;
        db   = (v.d == 2) ? 16 : 8;
        bu   = (v.d != 1);
        bad0 = miso_bad;
        rw[v.d]   = v.rd;
        cs_n[v.d] = 1'b0;
        tick();
        chk("start_overrun", int'(o_ovr[v.d]), 0);
        chk("start_wcount", int'(o_wc[v.d]), 0);
        chk("addr_we_hdr", int'(o_awe[v.d]), 1);
        for (int i = 0; i < nh; i++) begin
            pulse(v.d, m);
            if (i == nh - 1) begin
                chk("addr_we_latch", int'(o_awe[v.d]), 0);
                if (v.rd) push(v.d, 1, m + 2);
                if (v.inject) sclk[v.d] = 1'b1;
                tick();
                sclk[v.d] = 1'b0;
                if (v.rd && bu) win[v.d] = 1'b1;
                tick(); tick();
            end else begin
                tick(); tick(); tick();
            end
        end
        for (int j = 1; j <= v.nd; j++) begin
            pulse(v.d, m);
            lim = (j == v.nd) ? v.tail : 99;
            if ((j % db) == 0 && (bu || j == db)) begin
                if (!v.rd) begin
                    push(v.d, 0, m + 1);
                    if (bu && lim >= 2) push(v.d, 2, m + 2);
                end else if (bu) begin
                    push(v.d, 2, m + 1);
                    if (lim >= 2) push(v.d, 1, m + 2);
                end
            end
            if (j < v.nd) begin tick(); tick(); tick(); end
        end
        for (int t = 1; t < v.tail; t++) tick();
        cs_n[v.d] = 1'b1;
        tick();
        win[v.d] = 1'b0;
        chk("enables_off", int'({o_awe[v.d], o_sr[v.d], o_dm[v.d], o_miso[v.d], o_inc[v.d]}), 0);
        chk("word_count", int'(o_wc[v.d]), v.exp_wc);
        chk("overrun", int'(o_ovr[v.d]), int'(v.inject));
        chk("pending_pulses", sb.size(), 0);
        if (sb.size() != 0) sb.delete();
        if (v.rd && bu) chk("miso_gaps", miso_bad - bad0, 0);
        tick();
    endtask

    initial begin
        int m;
        //        dut rd    nd  tail inj   wc
        vt[0] = '{1, 1'b0, 12, 2, 1'b0, 1};   // single write, extra edges ignored
        vt[1] = '{0, 1'b1, 24, 1, 1'b0, 3};   // 3-word burst read
        vt[2] = '{0, 1'b0, 13, 1, 1'b0, 1};   // write aborted mid second word
        vt[3] = '{0, 1'b0,  8, 3, 1'b1, 1};   // overrun edge in LATCH
        vt[4] = '{0, 1'b0, 16, 2, 1'b0, 2};   // overrun cleared, 2-word write
        vt[5] = '{2, 1'b0, 32, 4, 1'b0, 2};   // 15/16-bit 2-word burst write
        vt[6] = '{1, 1'b1,  8, 3, 1'b0, 1};   // single-word read
        vt[7] = '{2, 1'b1, 16, 2, 1'b0, 1};   // wide read, reload after word

        reset_n = 1'b0;
        cs_n = 3'b111; sclk = 3'b000; rw = 3'b000; win = 3'b000;
        tick(); tick();
        for (int d = 0; d < 3; d++) begin
            chk("reset_outputs", int'({o_awe[d], o_sr[d], o_dm[d], o_miso[d], o_inc[d], o_ovr[d]}), 0);
            chk("reset_wcount", int'(o_wc[d]), 0);
        end
        reset_n = 1'b1;
        tick(); tick();

        cs_n[0] = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            pulse(0, m);
            tick(); tick(); tick();
        end
        chk("addr_we_pre_reset", int'(o_awe[0]), 1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({o_awe[0], o_sr[0], o_dm[0], o_miso[0], o_inc[0], o_ovr[0]}), 0);
        chk("async_reset_wcount", int'(o_wc[0]), 0);
        tick();
        cs_n[0] = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();

        for (int r = 0; r < 8; r++) run_frame(vt[r]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
